// File: rtl/rev_counter_ctrl_if.sv
// Handshake bundle for the reversible counter run controller.
// master = button front-end / display side, slave = controller.
interface rev_counter_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dir;
    logic             wrap_en;
    logic [CNT_W-1:0] cnt;
    logic             rc;
    logic             running;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, load, load_val, dir, wrap_en,
        input  cnt, rc, running, done, state
    );

    modport slave (
        input  start, stop, load, load_val, dir, wrap_en,
        output cnt, rc, running, done, state
    );
endinterface

// File: rtl/rev_counter_ctrl.sv
// Run controller for the 16-bit up/down counter with tick prescaler.
// Optional AUTO_REVERSE_EN: bounce at terminal count instead of halting.
module rev_counter_ctrl #(
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 100000000
) (
    input logic               clk,
    input logic               rst,
    rev_counter_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             done_q, done_d;
    logic             run_q;
    logic             dir_eff;
    logic             term;
    logic             tick;

`ifdef AUTO_REVERSE_EN
    logic dir_q, dir_d;

    assign dir_eff = dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end
`else
    assign dir_eff = bus.dir;
`endif

    assign term = dir_eff ? (cnt_q == '0) : (cnt_q == '1);
    assign tick = (state_q == RUN) && (pre_q == PRE_TOP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
`ifdef AUTO_REVERSE_EN
        dir_d   = dir_q;
`endif
        if (bus.load) begin
            cnt_d = bus.load_val;
            pre_d = '0;
            if (state_q == HALT) state_d = IDLE;
`ifdef AUTO_REVERSE_EN
            dir_d = bus.dir;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = RUN;
`ifdef AUTO_REVERSE_EN
                        dir_d = bus.dir;
`endif
                    end
                end
                RUN: begin
                    // a stop cycle freezes prescaler and count
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (term && !bus.wrap_en) begin
`ifdef AUTO_REVERSE_EN
                            dir_d = ~dir_q;
                            cnt_d = dir_q ? cnt_q + ONE : cnt_q - ONE;
`else
                            state_d = HALT;
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d = dir_eff ? cnt_q - ONE : cnt_q + ONE;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        pre_d   = '0;
                    end else if (bus.start) begin
                        state_d = RUN;
                    end
                end
                HALT: begin
                    if (bus.stop) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.rc      = term;
    assign bus.running = run_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_rev_counter_ctrl.sv
// Self-checking bench for rev_counter_ctrl with TICK_DIV=4.
// Directed scenarios plus randomized run against a behavioural model.
module tb_rev_counter_ctrl;
    localparam int W  = 16;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rev_counter_ctrl_if #(.CNT_W(W)) bus ();

    rev_counter_ctrl #(.CNT_W(W), .TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt, m_pre, m_st;
    bit m_done, m_dir;

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_st = 0; m_done = 0; m_dir = 0;
    endtask

    function automatic bit cur_dir();
`ifdef AUTO_REVERSE_EN
        return m_dir;
`else
        return bus.dir;
`endif
    endfunction

    function automatic bit exp_rc();
        return cur_dir() ? (m_cnt == 0) : (m_cnt == 65535);
    endfunction

    task automatic model_edge();
        bit d;
        d = cur_dir();
        m_done = 0;
        if (bus.load) begin
            m_cnt = int'(bus.load_val);
            m_pre = 0;
            if (m_st == 3) m_st = 0;
`ifdef AUTO_REVERSE_EN
            m_dir = bus.dir;
`endif
        end else begin
            case (m_st)
                0: if (bus.start && !bus.stop) begin
                    m_st = 1;
`ifdef AUTO_REVERSE_EN
                    m_dir = bus.dir;
`endif
                end
                1: if (bus.stop) m_st = 2;
                   else if (m_pre == TD - 1) begin
                       m_pre = 0;
                       if (exp_rc() && !bus.wrap_en) begin
`ifdef AUTO_REVERSE_EN
                           m_dir = !m_dir;
                           m_cnt = (m_cnt + (m_dir ? 65535 : 1)) % 65536;
`else
                           m_st = 3;
                           m_done = 1;
`endif
                       end else begin
                           m_cnt = (m_cnt + (d ? 65535 : 1)) % 65536;
                       end
                   end else m_pre++;
                2: if (bus.stop) begin m_st = 0; m_pre = 0; end
                   else if (bus.start) m_st = 1;
                3: if (bus.stop) m_st = 0;
                default: ;
            endcase
        end
    endtask

    task automatic clr();
        bus.start = 0; bus.stop = 0; bus.load = 0;
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
        clr();
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) tick_edge();
    endtask

    task automatic apply_reset();
        rst = 1;
        #2;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        clr();
        bus.load_val = '0; bus.dir = 0; bus.wrap_en = 1;
        #2;
        checks++;
        if ({bus.cnt, bus.state, bus.running, bus.done} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0",
                     {bus.cnt, bus.state, bus.running, bus.done});
        end
        #6;
        rst = 0;
        model_reset();
    endtask

    task automatic test_up_count();
        bus.dir = 0; bus.wrap_en = 1; bus.start = 1;
        tick_edge();
        checks++;
        if (bus.running !== 1 || bus.state !== 2'd1 || bus.cnt !== 16'h0) begin
            errors++;
            $display("FAIL up_enter: run=%b st=%0d cnt=%h want 1 1 0000",
                     bus.running, bus.state, bus.cnt);
        end
        edges(3);
        checks++;
        if (bus.cnt !== 16'h0) begin
            errors++; $display("FAIL up_edge3: cnt=%h want 0000", bus.cnt);
        end
        edges(1);
        checks++;
        if (bus.cnt !== 16'h1) begin
            errors++; $display("FAIL up_edge4: cnt=%h want 0001", bus.cnt);
        end
        edges(4);
        checks++;
        if (bus.cnt !== 16'h2 || bus.running !== 1) begin
            errors++;
            $display("FAIL up_edge8: cnt=%h run=%b want 0002 1", bus.cnt, bus.running);
        end
        edges(12);
        checks++;
        if (bus.cnt !== 16'h5) begin
            errors++; $display("FAIL up_edge20: cnt=%h want 0005", bus.cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1;
        #1;
        checks++;
        if (bus.cnt !== 16'h0 || bus.state !== 2'd0 || bus.running !== 0) begin
            errors++;
            $display("FAIL reset_mid: cnt=%h st=%0d run=%b want 0 0 0",
                     bus.cnt, bus.state, bus.running);
        end
        #2;
        rst = 0;
        model_reset();
    endtask

    task automatic test_wrap();
        bus.dir = 0; bus.wrap_en = 1;
        bus.load = 1; bus.load_val = 16'hFFFE;
        tick_edge();
        bus.start = 1;
        tick_edge();
        edges(4);
        checks++;
        if (bus.cnt !== 16'hFFFF || bus.rc !== 1) begin
            errors++;
            $display("FAIL wrap_up_ffff: cnt=%h rc=%b want ffff 1", bus.cnt, bus.rc);
        end
        edges(4);
        checks++;
        if (bus.cnt !== 16'h0 || bus.state !== 2'd1) begin
            errors++;
            $display("FAIL wrap_up_0000: cnt=%h st=%0d want 0000 1", bus.cnt, bus.state);
        end
        bus.dir = 1; bus.load = 1; bus.load_val = 16'h0001;
        tick_edge();
        edges(4);
        checks++;
        if (bus.cnt !== 16'h0 || bus.rc !== 1) begin
            errors++;
            $display("FAIL wrap_dn_0000: cnt=%h rc=%b want 0000 1", bus.cnt, bus.rc);
        end
        edges(4);
        checks++;
        if (bus.cnt !== 16'hFFFF || bus.state !== 2'd1) begin
            errors++;
            $display("FAIL wrap_dn_ffff: cnt=%h st=%0d want ffff 1", bus.cnt, bus.state);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        bus.dir = 1; bus.wrap_en = 0;
        bus.load = 1; bus.load_val = 16'h0001;
        tick_edge();
        bus.start = 1;
        tick_edge();
        edges(4);
        checks++;
        if (bus.cnt !== 16'h0) begin
            errors++; $display("FAIL halt_reach0: cnt=%h want 0000", bus.cnt);
        end
        edges(4);
`ifdef AUTO_REVERSE_EN
        checks++;
        if (bus.cnt !== 16'h1 || bus.state !== 2'd1 || bus.done !== 0) begin
            errors++;
            $display("FAIL auto_rev: cnt=%h st=%0d done=%b want 0001 1 0",
                     bus.cnt, bus.state, bus.done);
        end
        edges(4);
        checks++;
        if (bus.cnt !== 16'h2) begin
            errors++; $display("FAIL auto_rev_next: cnt=%h want 0002", bus.cnt);
        end
        bus.stop = 1; tick_edge();
        bus.stop = 1; tick_edge();
`else
        checks++;
        if (bus.done !== 1 || bus.state !== 2'd3 || bus.cnt !== 16'h0 ||
            bus.running !== 0) begin
            errors++;
            $display("FAIL halt_enter: done=%b st=%0d cnt=%h run=%b want 1 3 0000 0",
                     bus.done, bus.state, bus.cnt, bus.running);
        end
        tick_edge();
        checks++;
        if (bus.done !== 0 || bus.state !== 2'd3) begin
            errors++;
            $display("FAIL halt_pulse: done=%b st=%0d want 0 3", bus.done, bus.state);
        end
        bus.start = 1;
        tick_edge();
        edges(4);
        checks++;
        if (bus.state !== 2'd3 || bus.cnt !== 16'h0) begin
            errors++;
            $display("FAIL halt_start: st=%0d cnt=%h want 3 0000", bus.state, bus.cnt);
        end
        bus.stop = 1;
        tick_edge();
`endif
        checks++;
        if (bus.state !== 2'd0) begin
            errors++; $display("FAIL halt_stop: st=%0d want 0", bus.state);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        bus.dir = 0; bus.wrap_en = 1; bus.start = 1;
        tick_edge();
        edges(2);
        bus.stop = 1;
        tick_edge();
        edges(5);
        checks++;
        if (bus.state !== 2'd2 || bus.cnt !== 16'h0 || bus.running !== 0) begin
            errors++;
            $display("FAIL pause_hold: st=%0d cnt=%h run=%b want 2 0000 0",
                     bus.state, bus.cnt, bus.running);
        end
        bus.start = 1;
        tick_edge();
        edges(1);
        checks++;
        if (bus.cnt !== 16'h0 || bus.state !== 2'd1) begin
            errors++;
            $display("FAIL resume_1: cnt=%h st=%0d want 0000 1", bus.cnt, bus.state);
        end
        edges(1);
        checks++;
        if (bus.cnt !== 16'h1) begin
            errors++; $display("FAIL resume_2: cnt=%h want 0001", bus.cnt);
        end
    endtask

    task automatic test_priority();
        bus.load = 1; bus.stop = 1; bus.start = 1; bus.load_val = 16'h1234;
        tick_edge();
        checks++;
        if (bus.cnt !== 16'h1234 || bus.state !== 2'd1) begin
            errors++;
            $display("FAIL prio_load: cnt=%h st=%0d want 1234 1", bus.cnt, bus.state);
        end
        edges(3);
        checks++;
        if (bus.cnt !== 16'h1234) begin
            errors++; $display("FAIL prio_pre3: cnt=%h want 1234", bus.cnt);
        end
        edges(1);
        checks++;
        if (bus.cnt !== 16'h1235) begin
            errors++; $display("FAIL prio_pre4: cnt=%h want 1235", bus.cnt);
        end
        edges(3);
        bus.load = 1; bus.load_val = 16'h0100;
        tick_edge();
        checks++;
        if (bus.cnt !== 16'h0100) begin
            errors++; $display("FAIL load_vs_tick: cnt=%h want 0100", bus.cnt);
        end
        edges(4);
        checks++;
        if (bus.cnt !== 16'h0101) begin
            errors++; $display("FAIL load_vs_tick_next: cnt=%h want 0101", bus.cnt);
        end
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        logic [15:0] vals [4];
        vals[0] = 16'h0000; vals[1] = 16'h0001;
        vals[2] = 16'hFFFE; vals[3] = 16'hFFFF;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop  = ($urandom_range(0, 15) == 0);
            bus.load  = ($urandom_range(0, 19) == 0);
            bus.load_val = ($urandom_range(0, 1) == 0) ?
                           vals[$urandom_range(0, 3)] : 16'($urandom);
            if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 29) == 0) bus.wrap_en = ~bus.wrap_en;
            @(posedge clk);
            model_edge();
            #1;
            got = {bus.cnt, bus.state, bus.running, bus.done, bus.rc};
            exp = {16'(m_cnt), 2'(m_st), m_st == 1, m_done, exp_rc()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_%0d: got cnt/st/run/done/rc=%h want %h",
                         i, got, exp);
            end
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_reset_mid();
        test_wrap();
        test_halt();
        test_pause();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
